// File: rtl/dac8413_multi_if_if.sv
// Shared parallel bus of the quad DAC chips. All chips see the same data,
// address and control lines; each chip has its own chip select.
//   dac_reset_n : DAC reset, active low
//   dac_rw      : 1 = read, 0 = write
//   dac_cs_n    : per-chip select, active low
//   dac_ldac_n  : shared load strobe, active low
//   dac_a       : channel address A1:A0 within a chip
//   dac_db      : data bus
// master = the driver side, slave = the DAC pins side.
interface dac8413_multi_if_if #(
    parameter int NUM_CHIPS = 2,
    parameter int DAC_BITS  = 12
);
    logic                 dac_reset_n;
    logic                 dac_rw;
    logic [NUM_CHIPS-1:0] dac_cs_n;
    logic                 dac_ldac_n;
    logic [1:0]           dac_a;
    logic [DAC_BITS-1:0]  dac_db;

    modport master (
        output dac_reset_n, dac_rw, dac_cs_n, dac_ldac_n, dac_a, dac_db
    );

    modport slave (
        input dac_reset_n, dac_rw, dac_cs_n, dac_ldac_n, dac_a, dac_db
    );
endinterface

// File: rtl/dac8413_multi_if.sv
// Driver for NUM_CHIPS quad parallel DACs sharing one bus.
// Each channel keeps a shadow of the last value written. Whenever an input
// setpoint differs from its shadow (or a refresh has been requested), one
// channel is chosen by fixed-priority or round-robin arbitration and written
// with the LDAC-high / LDAC-low setup / CS write / hold sequence.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ch_data    : NCH setpoints, channel k at [k*DATA_W +: DATA_W]
//   refresh    : one-cycle pulse, rewrite every channel
//   bus        : DAC pin bundle (master side)
//   busy       : high in every state except IDLE
//   last_ch    : most recently selected channel (low 3 bits of its index)
module dac8413_multi_if #(
    parameter int CLK_FREQ_HZ    = 22118400,
    parameter int NUM_CHIPS      = 2,
    parameter int DATA_W         = 8,
    parameter int DAC_BITS       = 12,
    parameter int ARB_MODE       = 0,
    parameter int T_RST_NS       = 1000,
    parameter int T_LDAC_HIGH_NS = 300,
    parameter int T_LS_NS        = 300,
    parameter int T_WCS_NS       = 500,
    parameter int T_LH_NS        = 300
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [4*NUM_CHIPS*DATA_W-1:0]   ch_data,
    input  logic                            refresh,
    dac8413_multi_if_if.master              bus,
    output logic                            busy,
    output logic [2:0]                      last_ch
);
    localparam int NCH = 4 * NUM_CHIPS;

    // Cycles covering t_ns, rounded up, never less than one.
    function automatic longint ncyc(input longint t_ns);
        longint c;
        c = (t_ns * longint'(CLK_FREQ_HZ) + 999999999) / 1000000000;
        return (c < 1) ? 1 : c;
    endfunction

    localparam longint N_RST  = ncyc(longint'(T_RST_NS));
    localparam longint N_LDAC = ncyc(longint'(T_LDAC_HIGH_NS));
    localparam longint N_LS   = ncyc(longint'(T_LS_NS));
    localparam longint N_WCS  = ncyc(longint'(T_WCS_NS));
    localparam longint N_LH   = ncyc(longint'(T_LH_NS));

    if (N_RST > 65535 || N_LDAC > 65535 || N_LS > 65535 ||
        N_WCS > 65535 || N_LH > 65535) begin : g_bad_timing
        $error("dac8413_multi_if: phase length exceeds 16-bit counter");
    end
    if (NUM_CHIPS < 1 || NUM_CHIPS > 4 || DATA_W < 1 || DATA_W > DAC_BITS) begin : g_bad_size
        $error("dac8413_multi_if: NUM_CHIPS or DATA_W out of range");
    end

    // Terminal counts: a phase of N cycles ends when the counter reads N-1.
    localparam logic [15:0] LIM_RST  = 16'(N_RST - 1);
    localparam logic [15:0] LIM_LDAC = 16'(N_LDAC - 1);
    localparam logic [15:0] LIM_LS   = 16'(N_LS - 1);
    localparam logic [15:0] LIM_WCS  = 16'(N_WCS - 1);
    localparam logic [15:0] LIM_LH   = 16'(N_LH - 1);

    typedef enum logic [2:0] {
        S_RST_HOLD = 3'd0,
        S_IDLE     = 3'd1,
        S_LDAC_HI  = 3'd2,
        S_LS       = 3'd3,
        S_WR       = 3'd4,
        S_LH       = 3'd5
    } state_t;

    state_t                state_reg, state_next;
    logic [15:0]           cnt_reg, cnt_next;
    logic                  dac_reset_n_reg, dac_reset_n_next;
    logic                  rw_reg, rw_next;
    logic [NUM_CHIPS-1:0]  cs_n_reg, cs_n_next;
    logic                  ldac_n_reg, ldac_n_next;
    logic [1:0]            a_reg, a_next;
    logic [DAC_BITS-1:0]   db_reg, db_next;
    logic [1:0]            chip_reg, chip_next;
    logic                  busy_reg, busy_next;
    logic [2:0]            last_ch_reg, last_ch_next;
    logic [3:0]            rr_ptr_reg, rr_ptr_next;
    logic [NCH-1:0]        refresh_req_reg, refresh_req_next;
    logic [DATA_W-1:0]     shadow_reg [NCH];
    logic [DATA_W-1:0]     shadow_next [NCH];

    logic [DATA_W-1:0]     ch_word [NCH];
    logic [NCH-1:0]        pending;
    logic                  sel_found;
    logic [3:0]            sel_idx;
    logic [DATA_W-1:0]     sel_data;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        assign ch_word[gi] = ch_data[gi*DATA_W +: DATA_W];
        assign pending[gi] = (ch_word[gi] != shadow_reg[gi]) | refresh_req_reg[gi];
    end

    // Descending scan so the last hit is the lowest index. In round-robin
    // mode a hit at or after the pointer takes precedence, otherwise the
    // search wraps to the lowest pending index.
    always_comb begin
        logic       lo_found, hi_found;
        logic [3:0] lo_idx, hi_idx;
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (pending[k]) begin
                lo_found = 1'b1;
                lo_idx   = 4'(k);
                if (ARB_MODE == 1 && 4'(k) >= rr_ptr_reg) begin
                    hi_found = 1'b1;
                    hi_idx   = 4'(k);
                end
            end
        end
        sel_found = lo_found;
        sel_idx   = hi_found ? hi_idx : lo_idx;
        sel_data  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_idx == 4'(k)) sel_data = ch_word[k];
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg + 16'd1;
        dac_reset_n_next = dac_reset_n_reg;
        rw_next          = rw_reg;
        cs_n_next        = cs_n_reg;
        ldac_n_next      = ldac_n_reg;
        a_next           = a_reg;
        db_next          = db_reg;
        chip_next        = chip_reg;
        busy_next        = busy_reg;
        last_ch_next     = last_ch_reg;
        rr_ptr_next      = rr_ptr_reg;
        refresh_req_next = refresh_req_reg;
        shadow_next      = shadow_reg;

        case (state_reg)
            S_RST_HOLD: begin
                if (cnt_reg == LIM_RST) begin
                    state_next       = S_IDLE;
                    cnt_next         = '0;
                    dac_reset_n_next = 1'b1;
                    busy_next        = 1'b0;
                end
            end
            S_IDLE: begin
                cnt_next    = '0;
                rw_next     = 1'b1;
                cs_n_next   = '1;
                ldac_n_next = 1'b1;
                a_next      = '0;
                db_next     = '0;
                busy_next   = 1'b0;
                if (sel_found) begin
                    state_next   = S_LDAC_HI;
                    busy_next    = 1'b1;
                    a_next       = sel_idx[1:0];
                    chip_next    = sel_idx[3:2];
                    db_next      = DAC_BITS'(sel_data) << (DAC_BITS - DATA_W);
                    last_ch_next = sel_idx[2:0];
                    rr_ptr_next  = (sel_idx == 4'(NCH - 1)) ? 4'd0 : sel_idx + 4'd1;
                    for (int k = 0; k < NCH; k++) begin
                        if (sel_idx == 4'(k)) begin
                            shadow_next[k]      = sel_data;
                            refresh_req_next[k] = 1'b0;
                        end
                    end
                end
            end
            S_LDAC_HI: begin
                if (cnt_reg == LIM_LDAC) begin
                    state_next  = S_LS;
                    cnt_next    = '0;
                    ldac_n_next = 1'b0;
                end
            end
            S_LS: begin
                if (cnt_reg == LIM_LS) begin
                    state_next = S_WR;
                    cnt_next   = '0;
                    rw_next    = 1'b0;
                    cs_n_next  = ~(NUM_CHIPS'(1) << chip_reg);
                end
            end
            S_WR: begin
                if (cnt_reg == LIM_WCS) begin
                    state_next = S_LH;
                    cnt_next   = '0;
                    rw_next    = 1'b1;
                    cs_n_next  = '1;
                end
            end
            S_LH: begin
                if (cnt_reg == LIM_LH) begin
                    state_next  = S_IDLE;
                    cnt_next    = '0;
                    ldac_n_next = 1'b1;
                    a_next      = '0;
                    db_next     = '0;
                    busy_next   = 1'b0;
                end
            end
            default: begin
                // Unreachable encodings: park in IDLE with the bus released.
                state_next       = S_IDLE;
                cnt_next         = '0;
                dac_reset_n_next = 1'b1;
                rw_next          = 1'b1;
                cs_n_next        = '1;
                ldac_n_next      = 1'b1;
                a_next           = '0;
                db_next          = '0;
                busy_next        = 1'b0;
            end
        endcase

        // A refresh pulse wins over the clear of the channel being selected.
        if (refresh) refresh_req_next = '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_RST_HOLD;
            cnt_reg         <= '0;
            dac_reset_n_reg <= 1'b0;
            rw_reg          <= 1'b1;
            cs_n_reg        <= '1;
            ldac_n_reg      <= 1'b1;
            a_reg           <= '0;
            db_reg          <= '0;
            chip_reg        <= '0;
            busy_reg        <= 1'b1;
            last_ch_reg     <= '0;
            rr_ptr_reg      <= '0;
            refresh_req_reg <= '0;
            shadow_reg      <= '{default: '0};
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            dac_reset_n_reg <= dac_reset_n_next;
            rw_reg          <= rw_next;
            cs_n_reg        <= cs_n_next;
            ldac_n_reg      <= ldac_n_next;
            a_reg           <= a_next;
            db_reg          <= db_next;
            chip_reg        <= chip_next;
            busy_reg        <= busy_next;
            last_ch_reg     <= last_ch_next;
            rr_ptr_reg      <= rr_ptr_next;
            refresh_req_reg <= refresh_req_next;
            shadow_reg      <= shadow_next;
        end
    end

    assign bus.dac_reset_n = dac_reset_n_reg;
    assign bus.dac_rw      = rw_reg;
    assign bus.dac_cs_n    = cs_n_reg;
    assign bus.dac_ldac_n  = ldac_n_reg;
    assign bus.dac_a       = a_reg;
    assign bus.dac_db      = db_reg;
    assign busy            = busy_reg;
    assign last_ch         = last_ch_reg;
endmodule

// File: tb/tb_dac8413_multi_if.sv
`timescale 1ns/1ps
module tb_dac8413_multi_if;
    localparam int NCH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH*8-1:0] ch_data;
    logic             refresh;
    logic             busy0, busy1;
    logic [2:0]       last0, last1;

    dac8413_multi_if_if #(.NUM_CHIPS(2), .DAC_BITS(12)) bus0 ();
    dac8413_multi_if_if #(.NUM_CHIPS(2), .DAC_BITS(12)) bus1 ();

    dac8413_multi_if #(.CLK_FREQ_HZ(20000000), .NUM_CHIPS(2), .DATA_W(8),
                       .DAC_BITS(12), .ARB_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .refresh(refresh),
        .bus(bus0), .busy(busy0), .last_ch(last0));

    dac8413_multi_if #(.CLK_FREQ_HZ(20000000), .NUM_CHIPS(2), .DATA_W(8),
                       .DAC_BITS(12), .ARB_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .refresh(refresh),
        .bus(bus1), .busy(busy1), .last_ch(last1));

    always #25 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pin views of both DUTs so one monitor loop covers them.
    logic [1:0]  cs_w   [2];
    logic [1:0]  a_w    [2];
    logic [11:0] db_w   [2];
    logic        rw_w   [2];
    logic        ldac_w [2];
    logic [2:0]  lc_w   [2];
    assign cs_w[0] = bus0.dac_cs_n;   assign cs_w[1] = bus1.dac_cs_n;
    assign a_w[0]  = bus0.dac_a;      assign a_w[1]  = bus1.dac_a;
    assign db_w[0] = bus0.dac_db;     assign db_w[1] = bus1.dac_db;
    assign rw_w[0] = bus0.dac_rw;     assign rw_w[1] = bus1.dac_rw;
    assign ldac_w[0] = bus0.dac_ldac_n; assign ldac_w[1] = bus1.dac_ldac_n;
    assign lc_w[0] = last0;           assign lc_w[1] = last1;

    // Write log: one entry per chip-select low window.
    int cyc;
    int nstart [2];
    int run    [2];
    bit in_wr  [2];
    int viol   [2];
    int wr_ch  [2][64];
    int wr_a   [2][64];
    int wr_cs  [2][64];
    int wr_db  [2][64];
    int wr_rw  [2][64];
    int wr_ld  [2][64];
    int wr_lc  [2][64];
    int wr_len [2][64];
    int wr_t   [2][64];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (cs_w[d] != 2'b11) begin
                if (cs_w[d] == 2'b00) viol[d] <= viol[d] + 1;
                if (!in_wr[d]) begin
                    in_wr[d] <= 1'b1;
                    run[d]   <= 1;
                    if (nstart[d] < 64) begin
                        wr_ch[d][nstart[d]] <= ((cs_w[d] == 2'b01) ? 4 : 0) + int'(a_w[d]);
                        wr_a[d][nstart[d]]  <= int'(a_w[d]);
                        wr_cs[d][nstart[d]] <= int'(cs_w[d]);
                        wr_db[d][nstart[d]] <= int'(db_w[d]);
                        wr_rw[d][nstart[d]] <= int'(rw_w[d]);
                        wr_ld[d][nstart[d]] <= int'(ldac_w[d]);
                        wr_lc[d][nstart[d]] <= int'(lc_w[d]);
                        wr_t[d][nstart[d]]  <= cyc;
                    end
                    nstart[d] <= nstart[d] + 1;
                end else begin
                    run[d] <= run[d] + 1;
                end
            end else if (in_wr[d]) begin
                in_wr[d] <= 1'b0;
                if (nstart[d] >= 1 && nstart[d] <= 64) wr_len[d][nstart[d]-1] <= run[d];
            end
        end
    end

    int e3_0 [3]  = '{0, 2, 6};
    int e3_1 [3]  = '{6, 0, 2};
    int e3_db[3]  = '{'h330, 'h220, 'h110};
    int e5a_1[8]  = '{2, 3, 4, 5, 6, 7, 0, 1};
    int e5b_0[11] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 6, 7};
    int e5b_1[11] = '{2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4};

    task automatic set_ch(input int k, input logic [7:0] v);
        ch_data[k*8 +: 8] = v;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    // Both DUTs idle for three consecutive samples, bounded.
    task automatic wait_idle(input int max_cyc);
        int quiet;
        quiet = 0;
        for (int i = 0; i < max_cyc && quiet < 3; i++) begin
            @(negedge clk);
            if (!busy0 && !busy1) quiet++;
            else quiet = 0;
        end
        check("idle_reached", int'(quiet >= 3), 1);
    endtask

    // Posedges from release until dac_reset_n is seen high.
    task automatic measure_hold(output int n);
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (bus0.dac_reset_n) done = 1'b1;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        bit found;
        rst_n = 1'b1;
        ch_data = '0;
        refresh = 1'b0;
        #10 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_dac_reset_n", bus0.dac_reset_n, 0);
        check("rst_rw", bus0.dac_rw, 1);
        check("rst_cs_n", bus0.dac_cs_n, 2'b11);
        check("rst_ldac_n", bus0.dac_ldac_n, 1);
        check("rst_a", bus0.dac_a, 0);
        check("rst_db", bus0.dac_db, 0);
        check("rst_busy", busy0, 1);
        check("rst_last_ch", last0, 0);

        // 1: reset hold length, no activity with zero inputs
        rst_n = 1'b1;
        measure_hold(n);
        check("t1_hold_cycles", n, 20);
        wait_idle(50);
        repeat (10) @(negedge clk);
        check("t1_no_writes", nstart[0] + nstart[1], 0);
        check("t1_busy_low", busy0, 0);

        // 2: single write of channel 5
        set_ch(5, 8'hA5);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy0) n++;
        end
        check("t2_busy_cycles", n, 28);
        check("t2_count", nstart[0], 1);
        check("t2_a", wr_a[0][0], 1);
        check("t2_cs_n", wr_cs[0][0], 2'b01);
        check("t2_db", wr_db[0][0], 'hA50);
        check("t2_cs_len", wr_len[0][0], 10);
        check("t2_rw", wr_rw[0][0], 0);
        check("t2_ldac", wr_ld[0][0], 0);
        check("t2_last_ch", last0, 5);

        // 3: three channels changed together
        base = nstart[0];
        set_ch(6, 8'h11); set_ch(2, 8'h22); set_ch(0, 8'h33);
        wait_idle(300);
        check("t3_count", nstart[0] - base, 3);
        for (int i = 0; i < 3; i++) begin
            check("t3_fixed_order", wr_ch[0][base+i], e3_0[i]);
            check("t3_fixed_db", wr_db[0][base+i], e3_db[i]);
            check("t3_fixed_lc", wr_lc[0][base+i], e3_0[i]);
            check("t3_rr_order", wr_ch[1][base+i], e3_1[i]);
        end
        check("t3_gap_a", wr_t[0][base+1] - wr_t[0][base], 29);
        check("t3_gap_b", wr_t[0][base+2] - wr_t[0][base+1], 29);
        check("t3_last_fixed", last0, 6);
        check("t3_last_rr", last1, 2);

        // 4: write channel 3, then change 1 and 7 together
        set_ch(3, 8'h44);
        wait_idle(100);
        base = nstart[0];
        check("t4_ch3", wr_ch[1][base-1], 3);
        set_ch(1, 8'h55); set_ch(7, 8'h66);
        wait_idle(200);
        check("t4_fixed_first", wr_ch[0][base], 1);
        check("t4_fixed_second", wr_ch[0][base+1], 7);
        check("t4_rr_first", wr_ch[1][base], 7);
        check("t4_rr_second", wr_ch[1][base+1], 1);
        check("t4_rr_db", wr_db[1][base], 'h660);

        // 5a: refresh rewrites every channel once
        base = nstart[0];
        pulse_refresh();
        wait_idle(600);
        check("t5a_count", nstart[0] - base, 8);
        for (int i = 0; i < 8; i++) begin
            check("t5a_fixed_order", wr_ch[0][base+i], i);
            check("t5a_rr_order", wr_ch[1][base+i], e5a_1[i]);
        end
        check("t5a_db_ch5", wr_db[0][base+5], 'hA50);
        check("t5a_cs_ch5", wr_cs[0][base+5], 2'b01);
        check("t5a_cs_ch2", wr_cs[0][base+2], 2'b10);

        // 5b: second refresh during the 3rd refresh transaction
        base = nstart[0];
        pulse_refresh();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (nstart[0] >= base + 3) found = 1'b1;
        end
        check("t5b_third_seen", found, 1);
        pulse_refresh();
        wait_idle(800);
        check("t5b_count", nstart[0] - base, 11);
        for (int i = 0; i < 11; i++) begin
            check("t5b_fixed_order", wr_ch[0][base+i], e5b_0[i]);
            check("t5b_rr_order", wr_ch[1][base+i], e5b_1[i]);
        end

        // 6: reset asserted during WR
        ch_data = '0;
        wait_idle(800);
        base = nstart[0];
        set_ch(4, 8'h77);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus0.dac_cs_n != 2'b11) found = 1'b1;
        end
        check("t6_wr_seen", found, 1);
        repeat (2) @(negedge clk);
        #10 rst_n = 1'b0;
        #1;
        check("t6_cs_n", bus0.dac_cs_n, 2'b11);
        check("t6_cs_n_rr", bus1.dac_cs_n, 2'b11);
        check("t6_dac_reset_n", bus0.dac_reset_n, 0);
        check("t6_rw", bus0.dac_rw, 1);
        check("t6_busy", busy0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        measure_hold(n);
        check("t6_hold_cycles", n, 20);
        wait_idle(300);
        check("t6_count", nstart[0] - base, 2);
        check("t6_abort_len", wr_len[0][base], 3);
        check("t6_rewrite_ch", wr_ch[0][base+1], 4);
        check("t6_rewrite_cs", wr_cs[0][base+1], 2'b01);
        check("t6_rewrite_db", wr_db[0][base+1], 'h770);
        check("t6_rewrite_len", wr_len[0][base+1], 10);
        check("t6_last_ch", last0, 4);

        check("cs_onehot", viol[0] + viol[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
